// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M multiply/divide sequencer with fixed latency
// One shared add/sub datapath: shift-add multiply, restoring divide, XLEN iterations.
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    state_t           state_q;
    logic [2:0]       op_q;
    logic [XLEN-1:0]  a_q;
    logic [XLEN-1:0]  b_q;
    logic             a_neg_q;
    logic             b_neg_q;
    logic [XLEN-1:0]  acc_q;
    logic [XLEN-1:0]  lo_q;
    logic [XLEN-1:0]  opb_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [XLEN-1:0]  result_q;

    logic             a_signed_d;
    logic             b_signed_d;
    logic             is_div;
    logic [XLEN-1:0]  a_abs_d;
    logic [XLEN-1:0]  b_abs_d;
    logic [XLEN+1:0]  add_a;
    logic [XLEN+1:0]  add_b;
    logic [XLEN+1:0]  add_sum;
    logic [XLEN:0]    mul_sel;
    logic [XLEN-1:0]  acc_d;
    logic [XLEN-1:0]  lo_d;
    logic [2*XLEN-1:0] prod_d;
    logic [XLEN-1:0]  quot_d;
    logic [XLEN-1:0]  rem_d;
    logic             div0_d;
    logic [XLEN-1:0]  result_d;

    assign a_signed_d = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign b_signed_d = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign is_div     = op_q[2];

    assign a_abs_d = a_neg_q ? -a_q : a_q;
    assign b_abs_d = b_neg_q ? -b_q : b_q;

    // Divide shifts the next dividend bit into the partial remainder before the trial subtract.
    assign add_a   = is_div ? {1'b0, acc_q, lo_q[XLEN-1]} : {2'b00, acc_q};
    assign add_b   = {2'b00, opb_q};
    assign add_sum = is_div ? (add_a - add_b) : (add_a + add_b);

    always_comb begin
        mul_sel = lo_q[0] ? add_sum[XLEN:0] : {1'b0, acc_q};
        if (is_div) begin
            acc_d = add_sum[XLEN+1] ? add_a[XLEN-1:0] : add_sum[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], ~add_sum[XLEN+1]};
        end else begin
            acc_d = mul_sel[XLEN:1];
            lo_d  = {mul_sel[0], lo_q[XLEN-1:1]};
        end
    end

    always_comb begin
        prod_d = (a_neg_q ^ b_neg_q) ? -{acc_q, lo_q} : {acc_q, lo_q};
        quot_d = (a_neg_q ^ b_neg_q) ? -lo_q : lo_q;
        rem_d  = a_neg_q ? -acc_q : acc_q;
        div0_d = (b_q == '0);
        case (op_q)
            OP_MUL:                       result_d = prod_d[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_d[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result_d = div0_d ? '1 : quot_d;
            OP_REM, OP_REMU:              result_d = div0_d ? a_q : rem_d;
            default:                      result_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            acc_q    <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start && !kill) begin
                        op_q    <= op;
                        a_q     <= rs1_val;
                        b_q     <= rs2_val;
                        a_neg_q <= a_signed_d & rs1_val[XLEN-1];
                        b_neg_q <= b_signed_d & rs2_val[XLEN-1];
                        busy_q  <= 1'b1;
                        state_q <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (kill) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        acc_q   <= '0;
                        lo_q    <= is_div ? a_abs_d : b_abs_d;
                        opb_q   <= is_div ? b_abs_d : a_abs_d;
                        cnt_q   <= CNT_W'(XLEN);
                        state_q <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (kill) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= acc_d;
                        lo_q  <= lo_d;
                        cnt_q <= (cnt_q == '0) ? '0 : cnt_q - 1'b1;
                        if (cnt_q <= CNT_W'(1)) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    busy_q <= 1'b0;
                    if (kill) begin
                        state_q <= S_IDLE;
                    end else begin
                        done_q   <= 1'b1;
                        result_q <= result_d;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        kill;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    muldiv_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .kill    (kill),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Caller sits at a falling edge; start is high for exactly one rising edge (acceptance).
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int pulse_at);
        int done_at;
        int busy_n;
        int done_n;
        logic [31:0] res;
        done_at = 0;
        busy_n  = 0;
        done_n  = 0;
        res     = '0;
        start   = 1'b1;
        op      = o;
        rs1_val = a;
        rs2_val = b;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (n == 1) begin
                rs1_val = ~a;
                rs2_val = ~b;
            end
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at == 0) begin
                    done_at = n;
                    res     = result;
                end
            end
            if (n == pulse_at) begin
                start   = 1'b1;
                op      = 3'b000;
                rs1_val = 32'h0000_1234;
                rs2_val = 32'h0000_0002;
            end else begin
                start = 1'b0;
            end
        end
        check({tag, " result"}, res, exp);
        check({tag, " latency"}, 32'(done_at), 32'd35);
        check({tag, " busy_cycles"}, 32'(busy_n), 32'd34);
        check({tag, " done_count"}, 32'(done_n), 32'd1);
        check({tag, " hold"}, result, exp);
    endtask

    initial begin
        int done_seen;
        rst     = 1'b1;
        start   = 1'b0;
        op      = 3'b000;
        rs1_val = '0;
        rs2_val = '0;
        kill    = 1'b0;
        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("MUL 7*-3",      3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        run_op("MULHU -1*-1",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        run_op("MULH -1*-1",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0);
        run_op("MULHSU -1*-1",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("MUL -1*-1",     3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op("DIV -7/2",      3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0);
        run_op("REM -7/2",      3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0);
        run_op("DIVU 100/7",    3'b101, 32'd100,        32'd7,         32'd14,        0);
        run_op("REMU 100/7",    3'b111, 32'd100,        32'd7,         32'd2,         0);
        run_op("DIV 5/0",       3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 0);
        run_op("REMU 5/0",      3'b111, 32'd5,          32'd0,         32'd5,         0);
        run_op("DIV ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);

        // Kill during the 10th ITER cycle of a MUL.
        done_seen = 0;
        start   = 1'b1;
        op      = 3'b000;
        rs1_val = 32'd11;
        rs2_val = 32'd13;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) done_seen++;
            if (n == 11) kill = 1'b1;
        end
        @(negedge clk);
        kill = 1'b0;
        check("kill busy", 32'(busy), 32'd0);
        check("kill done", 32'(done_seen + int'(done)), 32'd0);
        check("kill result", result, 32'h8000_0000);
        run_op("DIVU 9/3 after kill", 3'b101, 32'd9, 32'd3, 32'd3, 0);

        run_op("REM ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);
        run_op("MUL start busy", 3'b000, 32'd3,         32'd5,         32'd15,        5);
        run_op("DIVU start done", 3'b101, 32'd20,       32'd4,         32'd5,         35);

        // Reset in the middle of ITER.
        start   = 1'b1;
        op      = 3'b101;
        rs1_val = 32'd1000;
        rs2_val = 32'd10;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("midrst no done", 32'(done_seen), 32'd0);
        run_op("MULHU after rst", 3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
